// File: rtl/scan_display_if.sv
// Bundle of the digit-data inputs and the anode/cathode pin outputs of scan_display_ctrl.
// The master modport drives the digit data. The slave modport is the display controller.
interface scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    adj;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              cathode;
  logic                    dp_n;

  modport master (
    output digits, adj, blink_mask, dp,
    input  anode, cathode, dp_n
  );

  modport slave (
    input  digits, adj, blink_mask, dp,
    output anode, cathode, dp_n
  );
endinterface

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed seven-segment driver with internal scan/blink timing and hex decode.
// Decimal-point output is enabled by defining SCAN_DISPLAY_CTRL_DP_EN; otherwise dp_n is tied high.
module scan_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic           clk_sys,
  input  logic           rst_n,
  scan_display_if.slave  bus
);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            cathode_q, cathode_d;
  logic                  scan_tick;
  logic                  blank;
  logic [3:0]            cur_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    scan_tick     = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d    = scan_tick ? '0 : scan_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (scan_tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // Blink timing restarts from zero whenever adjust mode is left.
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (bus.adj) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
      end
    end

    cur_digit = bus.digits[{idx_q, 2'b00} +: 4];
    blank     = bus.adj & blink_phase_q & bus.blink_mask[idx_q];
    anode_d   = ~(NUM_DIGITS'(1) << idx_q);
    cathode_d = blank ? 7'b1111111 : seg_decode(cur_digit);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      anode_q       <= '1;
      cathode_q     <= 7'b1111111;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
    end
  end

  assign bus.anode   = anode_q;
  assign bus.cathode = cathode_q;

`ifdef SCAN_DISPLAY_CTRL_DP_EN
  logic dp_n_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) dp_n_q <= 1'b1;
    else        dp_n_q <= blank | ~bus.dp[idx_q];
  end

  assign bus.dp_n = dp_n_q;
`else
  logic unused_dp;

  assign unused_dp = ^bus.dp;
  assign bus.dp_n  = 1'b1;
`endif

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Self-checking bench: table-driven hex decode, hand sequences, and randomized checks vs. a timing model.
module tb_scan_display_ctrl;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 16;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  scan_display_if #(.NUM_DIGITS(4)) if4 ();
  scan_display_if #(.NUM_DIGITS(1)) if1 ();
  scan_display_if #(.NUM_DIGITS(6)) if6 ();

  scan_display_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(SD), .BLINK_DIV(BD)) u4 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(if4));
  scan_display_ctrl #(.NUM_DIGITS(1), .SCAN_DIV(1), .BLINK_DIV(2)) u1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(if1));
  scan_display_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(1), .BLINK_DIV(3)) u6 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(if6));

  typedef struct {
    logic [3:0] val;
    logic [6:0] cat;
  } vec_t;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int checks = 0;
  int errors = 0;
  int n4 = 0;          // edges since reset release
  int a4 = 0;          // consecutive edges with adj=1
  int blanks_seen = 0;
  int dp_low_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict the pins after the next edge from the current inputs and elapsed time.
  task automatic step4(input string tag);
    int         idx;
    bit         phase;
    bit         blank;
    logic [3:0] ea;
    logic [6:0] ec;
    logic       edp;
    logic       adj_at;
    logic [15:0] dg;
    idx    = (n4 / SD) % ND;
    phase  = ((a4 / BD) % 2) == 1;
    blank  = if4.adj && phase && if4.blink_mask[idx];
    ea     = ~(4'b0001 << idx);
    dg     = if4.digits;
    ec     = blank ? 7'b1111111 : seg_tab[(dg >> (4 * idx)) & 16'hF];
`ifdef SCAN_DISPLAY_CTRL_DP_EN
    edp    = blank | ~if4.dp[idx];
`else
    edp    = 1'b1;
`endif
    adj_at = if4.adj;
    @(posedge clk_sys);
    #1;
    chk({tag, "_anode"},   32'(if4.anode),   32'(ea));
    chk({tag, "_cathode"}, 32'(if4.cathode), 32'(ec));
    chk({tag, "_dp_n"},    32'(if4.dp_n),    32'(edp));
    if (blank) blanks_seen++;
    if (!edp) dp_low_seen++;
    n4++;
    a4 = adj_at ? a4 + 1 : 0;
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_anode4"},   32'(if4.anode),   32'hF);
    chk({tag, "_cathode4"}, 32'(if4.cathode), 32'h7F);
    chk({tag, "_dp_n4"},    32'(if4.dp_n),    32'h1);
    chk({tag, "_anode1"},   32'(if1.anode),   32'h1);
    chk({tag, "_anode6"},   32'(if6.anode),   32'h3F);
    chk({tag, "_cathode6"}, 32'(if6.cathode), 32'h7F);
  endtask

  vec_t vecs [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].val = 4'(i);
      vecs[i].cat = seg_tab[i];
    end
    if4.digits = 16'h4321; if4.adj = 0; if4.blink_mask = '0; if4.dp = '0;
    if1.digits = '0;       if1.adj = 0; if1.blink_mask = '0; if1.dp = '0;
    if6.digits = 24'h543210; if6.adj = 0; if6.blink_mask = '0; if6.dp = '0;

    // Reset state, then release away from the edge.
    #12;
    check_reset_pins("rst");
    @(posedge clk_sys); #1;
    check_reset_pins("rst_hold");
    rst_n = 1'b1;
    n4 = 0; a4 = 0;

    // Scan order with 16'h4321.
    repeat (32) step4("scan");

    // Blink on digits 0 and 1, then leave adjust mode.
    blanks_seen = 0;
    if4.adj = 1'b1; if4.blink_mask = 4'b0011;
    repeat (64) step4("blink");
    chk("blink_windows_seen", 32'(blanks_seen > 0), 32'h1);
    if4.adj = 1'b0;
    repeat (8) step4("unblink");

    // Decimal point on digit 2, then with digit 2 blanking.
    dp_low_seen = 0;
    if4.dp = 4'b0100;
    repeat (16) step4("dp");
`ifdef SCAN_DISPLAY_CTRL_DP_EN
    chk("dp_low_seen", 32'(dp_low_seen > 0), 32'h1);
`else
    chk("dp_never_low", 32'(dp_low_seen), 32'h0);
`endif
    if4.adj = 1'b1; if4.blink_mask = 4'b0100;
    repeat (48) step4("dp_blink");
    if4.adj = 1'b0; if4.dp = '0; if4.blink_mask = '0;

    // Async reset while idx=2, bounded search.
    for (int k = 0; k < 16; k++) begin
      if (((n4 / SD) % ND) == 2) break;
      step4("seek");
    end
    chk("seek_idx2", 32'((n4 / SD) % ND), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_pins("async_rst");
    @(posedge clk_sys); #1;
    check_reset_pins("async_rst_hold");
    rst_n = 1'b1;
    n4 = 0; a4 = 0;
    step4("restart");
    chk("restart_anode", 32'(if4.anode), 32'hE);

    // Randomized traffic against the model.
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 7) == 0)  if4.digits = 16'($urandom);
      if ($urandom_range(0, 39) == 0) if4.adj = ~if4.adj;
      if ($urandom_range(0, 15) == 0) if4.blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) if4.dp = 4'($urandom);
      step4("rand");
    end

    // One-digit hex decode sweep and six-digit wrap, after a fresh reset.
    @(posedge clk_sys); #1;
    rst_n = 1'b0;
    #1;
    chk("rst2_anode6", 32'(if6.anode), 32'h3F);
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [5:0] ea6;
      ea6 = ~(6'b000001 << (i % 6));
      if1.digits = vecs[i].val;
      @(posedge clk_sys); #1;
      chk($sformatf("hex_%0h_cathode", vecs[i].val), 32'(if1.cathode), 32'(vecs[i].cat));
      chk("one_digit_anode", 32'(if1.anode), 32'h0);
      chk($sformatf("wrap6_anode_%0d", i), 32'(if6.anode), 32'(ea6));
    end
    chk("hex_F_final", 32'(if1.cathode), 32'h38);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
- Parametrised, time-multiplexed seven-segment driver for the stopwatch display; successor to the fixed 4-digit scanner.
- Takes packed hex/BCD digit values and decodes them internally. Generates its own scan and blink timing from the single system clock instead of external clk_fast/clk_blink.
- Blanks selected digits at the blink rate during adjust mode. Sits between the counter datapath and the board anode/cathode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (legal 1..8)
SCAN_DIV, 100000, clk_sys cycles per digit slot (legal >= 1)
BLINK_DIV, 25000000, clk_sys cycles per blink half-period (legal >= 1)

Ports:
clk_sys  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
digits  in  4*NUM_DIGITS  packed digit values; digit k = digits[4k+3:4k], digit 0 rightmost
adj  in  1  adjust mode; enables blinking
blink_mask  in  NUM_DIGITS  bit k=1: digit k blinks while adj=1
dp  in  NUM_DIGITS  per-digit decimal point request (used only with macro)
anode  out  NUM_DIGITS  active-low one-hot digit enable; anode[k] drives digit k
cathode  out  7  active-low segments, cathode[6:0] = {a,b,c,d,e,f,g}
dp_n  out  1  active-low decimal point segment

Behaviour:
- Reset (rst_n=0, asynchronous): anode all 1, cathode 7'b1111111, dp_n 1, scan counter 0, digit index 0, blink counter 0, blink_phase 0.
- Scan counter counts 0..SCAN_DIV-1. scan_tick is asserted on the cycle the count equals SCAN_DIV-1; the counter wraps to 0.
- SCAN_DIV=1: scan_tick is asserted every cycle.
- On scan_tick the digit index advances idx -> idx+1, wrapping NUM_DIGITS-1 -> 0. NUM_DIGITS=1: idx stays 0.
- Outputs are registered every cycle from the current idx and current inputs. One-cycle latency from an idx change or a digits/blink_mask/adj/dp change to the pins.
  - anode = ~(1<<idx)
  - cathode = decode(digit idx), or blank
- Pins hold stable for SCAN_DIV cycles per digit. The first visible digit after reset is digit 0, one cycle after release.
- Decode covers the full hex range, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Blink counter counts 0..BLINK_DIV-1 while adj=1. blink_phase toggles on each wrap.
- While adj=0: blink counter and blink_phase are held at 0, so digits are visible immediately when adj drops. On adj 0->1 the first blank occurs BLINK_DIV cycles later.
- Blank condition: adj=1 and blink_phase=1 and blink_mask[idx]=1 → cathode 7'b1111111 and dp_n 1. anode is still driven normally.
- Scan and blink counters are independent. A scan_tick coinciding with a blink toggle applies both on the same edge.
- rst_n asserted mid-scan forces reset values within the same cycle (asynchronous). Scanning restarts at digit 0.
- No X on outputs for any input combination; unused dp bits are ignored.

Optional Feature:
Macro SCAN_DISPLAY_CTRL_DP_EN.
- Defined: dp_n = ~dp[idx], registered with the same latency as cathode, and forced to 1 when the digit is blanked.
- Undefined: dp_n is constant 1, the dp input is ignored, and no dp logic is synthesised.

Test Plan:
1. Reset/scan order (NUM_DIGITS=4, SCAN_DIV=4): release rst_n, digits=16'h4321 -> anode sequence 1110,1101,1011,0111, repeating, each held 4 cycles; cathode 1001111, 0010010, 0000110, 1001100 in step.
2. Hex decode: sweep digit 0 through 0..F with SCAN_DIV=1, NUM_DIGITS=1 -> cathode matches the table one cycle after each change; F gives 0111000.
3. Blink (BLINK_DIV=16, adj=1, blink_mask=4'b0011) -> digits 0 and 1 show cathode 1111111 during the 16-cycle blink_phase=1 windows. Digits 2 and 3 are never blanked. adj->0 restores digits 0 and 1 on the next cycle.
4. Async reset mid-operation: assert rst_n=0 between clock edges while idx=2 -> anode 1111 and cathode 1111111 immediately. After release, scanning restarts at anode 1110.
5. Wrap and parameter corners: NUM_DIGITS=6, SCAN_DIV=1 -> anode cycles through 6 one-hot values and wraps 011111->111110. NUM_DIGITS=1 -> anode constant 0 after reset.
6. DP (macro defined, dp=4'b0100, blink inactive) -> dp_n=0 only in digit 2's slot. With digit 2 blanking (adj=1, blink_mask=4'b0100, blink_phase=1) -> dp_n=1. With macro undefined -> dp_n always 1.
